// File: rtl/cellrv32_tmr_sched.sv
// cellrv32_tmr_sched: multi-channel timer event scheduler.
// One prescaled 32-bit time base and one deadline comparator are shared by
// NUM_CH channels; a round-robin pointer evaluates one channel per clock and
// channel events are merged into a single level-type interrupt.
module cellrv32_tmr_sched #(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  output logic        irq_o
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // bus decode; byte offset must be word aligned to hit a register
  logic       acc, rd, wr;
  logic [7:0] off;
  assign acc = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign rd  = acc & rden_i;
  assign wr  = acc & wren_i;
  assign off = addr_i[7:0];

  logic        wr_ctrl, wr_count, wr_pend;
  assign wr_ctrl  = wr & (off == 8'h00);
  assign wr_count = wr & (off == 8'h04);
  assign wr_pend  = wr & (off == 8'h08);

  // global state
  logic          en_q;
  logic [2:0]    prsc_q;
  logic          tick_q;
  logic [31:0]   count_q;
  logic [PW-1:0] ptr_q;
  logic          ack_q, irq_q;
  logic [31:0]   data_q, data_d;

  // per-channel state
  logic [NUM_CH-1:0] ch_en_q, ch_per_q, ch_ie_q, pend_q;
  logic [31:0]       ch_cmp_q [NUM_CH];
  logic [31:0]       ch_rel_q [NUM_CH];

  // shared comparator: wrap-safe "count has reached CMP" test for channel ptr
  logic [31:0] diff;
  logic        due;
  assign diff = count_q - ch_cmp_q[ptr_q];
  assign due  = en_q & ch_en_q[ptr_q] & ~diff[31];

  // control register, prescaler tap and time base
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      prsc_q  <= 3'd0;
      tick_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      tick_q <= clkgen_i[prsc_q];
      if (wr_ctrl) begin
        en_q   <= data_i[0];
        prsc_q <= data_i[3:1];
      end
      if (wr_count) begin
        count_q <= data_i;
      end else if (en_q & tick_q) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // round-robin scan pointer, parked at channel 0 while disabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (!en_q || ptr_q == PW'(NUM_CH - 1)) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_q + PW'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic bus_hit, due_hit;
    // any write into this channel's register block overrides a due update
    assign bus_hit = wr & (off[7:4] == 4'(gi + 1)) & (off[1:0] == 2'b00) & (off[3:2] != 2'b11);
    assign due_hit = due & (ptr_q == PW'(gi));

    // channel registers: bus write first, then event reload / self-disable
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ch_en_q[gi]  <= 1'b0;
        ch_per_q[gi] <= 1'b0;
        ch_ie_q[gi]  <= 1'b0;
        ch_cmp_q[gi] <= 32'd0;
        ch_rel_q[gi] <= 32'd0;
      end else if (bus_hit) begin
        case (off[3:2])
          2'b00: begin
            ch_en_q[gi]  <= data_i[0];
            ch_per_q[gi] <= data_i[1];
            ch_ie_q[gi]  <= data_i[2];
          end
          2'b01:   ch_cmp_q[gi] <= data_i;
          default: ch_rel_q[gi] <= data_i;
        endcase
      end else if (due_hit) begin
        if (ch_per_q[gi]) begin
          ch_cmp_q[gi] <= ch_cmp_q[gi] + ch_rel_q[gi];
        end else begin
          ch_en_q[gi] <= 1'b0;
        end
      end
    end

    // pending flag: hardware set beats a simultaneous write-one-to-clear
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pend_q[gi] <= 1'b0;
      end else if (due_hit & ~bus_hit) begin
        pend_q[gi] <= 1'b1;
      end else if (wr_pend & data_i[gi]) begin
        pend_q[gi] <= 1'b0;
      end
    end
  end

  // read data mux; unmapped offsets return zero
  always_comb begin
    data_d = 32'd0;
    if (rd && off[1:0] == 2'b00) begin
      case (off)
        8'h00:   data_d = {28'd0, prsc_q, en_q};
        8'h04:   data_d = count_q;
        8'h08:   data_d[NUM_CH-1:0] = pend_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (off[7:4] == 4'(i + 1)) begin
              case (off[3:2])
                2'b00:   data_d = {29'd0, ch_ie_q[i], ch_per_q[i], ch_en_q[i]};
                2'b01:   data_d = ch_cmp_q[i];
                2'b10:   data_d = ch_rel_q[i];
                default: data_d = 32'd0;
              endcase
            end
          end
        end
      endcase
    end
  end

  // registered bus response and merged interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      data_q <= 32'd0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= rd | wr;
      data_q <= data_d;
      irq_q  <= |(pend_q & ch_ie_q);
    end
  end

  assign ack_o       = ack_q;
  assign data_o      = data_q;
  assign irq_o       = irq_q;
  assign clkgen_en_o = en_q;

endmodule
